// File: rtl/trigger_gen_pkg.sv
// Shared definitions for the UDAR trigger generator and its timing helpers.
package trigger_gen_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPulse = 2'd1,
    StHold  = 2'd2
  } state_e;

  localparam int unsigned DefCntLen   = 16;
  localparam int unsigned DefPrescale = 50;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trigger_gen_if.sv
// Start/busy/done handshake plus trigger pin between controller and trigger_gen.
interface trigger_gen_if #(
  parameter int unsigned CNT_LEN = 16
);
  logic               start;
  logic [CNT_LEN-1:0] width;
  logic [CNT_LEN-1:0] holdoff;
  logic               trig;
  logic               busy;
  logic               done;

  modport master (
    output start, width, holdoff,
    input  trig, busy, done
  );

  modport slave (
    input  start, width, holdoff,
    output trig, busy, done
  );
endinterface

// File: rtl/trigger_gen_tick_div.sv
// Tick prescaler: one-cycle tick every PRESCALE clocks, restartable via clr_i.
module tick_div
  import trigger_gen_pkg::*;
#(
  parameter int unsigned PRESCALE = DefPrescale
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned W    = cnt_width(PRESCALE);
  localparam logic [W-1:0] Last = W'(PRESCALE - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Tick on the last count of each period.
  always_comb begin
    tick_o = (cnt_q == Last);
  end

  // Wrap after the tick; a clear restarts the period from zero.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trigger_gen.sv
// UDAR trigger generator: one programmed-width pulse on trig, then a programmed hold-off.
module trigger_gen
  import trigger_gen_pkg::*;
#(
  parameter int unsigned CNT_LEN  = DefCntLen,
  parameter int unsigned PRESCALE = DefPrescale
) (
  input  logic          clk,
  input  logic          rst,
  trigger_gen_if.slave  ctrl_io
);

  state_e             state_q, state_d;
  logic [CNT_LEN-1:0] cnt_q, cnt_d;
  logic [CNT_LEN-1:0] holdoff_q, holdoff_d;
  logic               trig_q, trig_d;
  logic               done_q, done_d;
  logic               clr;
  logic               tick;
  logic               cycle_end;
  logic               last_tick;

  tick_div #(
    .PRESCALE (PRESCALE)
  ) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .tick_o (tick)
  );

  // Counter ends on the 1->0 step, so an all-ones operand never wraps.
  assign last_tick = tick && (cnt_q == CNT_LEN'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counter/operand loads and prescaler restart on every state entry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    holdoff_d = holdoff_q;
    clr       = 1'b0;
    cycle_end = 1'b0;
    case (state_q)
      StIdle: begin
        if (ctrl_io.start) begin
          clr       = 1'b1;
          holdoff_d = ctrl_io.holdoff;
          if (ctrl_io.width != '0) begin
            state_d = StPulse;
            cnt_d   = ctrl_io.width;
          end else if (ctrl_io.holdoff != '0) begin
            state_d = StHold;
            cnt_d   = ctrl_io.holdoff;
          end else begin
            cycle_end = 1'b1;
          end
        end
      end
      StPulse: begin
        if (tick) begin
          cnt_d = cnt_q - CNT_LEN'(1);
        end
        if (last_tick) begin
          clr = 1'b1;
          if (holdoff_q != '0) begin
            state_d = StHold;
            cnt_d   = holdoff_q;
          end else begin
            state_d   = StIdle;
            cycle_end = 1'b1;
          end
        end
      end
      StHold: begin
        if (tick) begin
          cnt_d = cnt_q - CNT_LEN'(1);
        end
        if (last_tick) begin
          clr       = 1'b1;
          state_d   = StIdle;
          cycle_end = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered outputs are derived from the next state so trig is glitch-free.
  always_comb begin
    trig_d          = (state_d == StPulse);
    done_d          = cycle_end;
    ctrl_io.trig    = trig_q;
    ctrl_io.done    = done_q;
    ctrl_io.busy    = (state_q != StIdle);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      holdoff_q <= '0;
      trig_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      holdoff_q <= holdoff_d;
      trig_q    <= trig_d;
      done_q    <= done_d;
    end
  end

endmodule
